// File: rtl/fifo_rd_drain.sv
// Read-domain drain for an async FIFO: pops with credit, absorbs RD_LAT read latency
// in a small output buffer and streams words out as valid/ready. Optional: FIFO_RD_DRAIN_STALL_CNT_EN.
module fifo_rd_drain #(
    parameter int unsigned DW         = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned OBUF_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             enable,
    input  logic             r_empty,
    input  logic [DW-1:0]    rdata,
    output logic             r_en,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] word_cnt
`ifdef FIFO_RD_DRAIN_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int unsigned PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(OBUF_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CW-1:0]     inflight_cnt;
    logic [CW-1:0]     obuf_cnt_q;
    logic [DW-1:0]     obuf_q [OBUF_DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic              capture;
    logic              xfer;
    logic              run;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = StStop;
            StStop: begin
                if (enable) begin
                    state_d = StRun;
                end else if (!busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The sum counts every word that will occupy a buffer slot, so a capture never overflows.
    always_comb begin
        run     = (state_q == StRun);
        state_o = state_q;
        r_en    = run && !r_empty && ((obuf_cnt_q + inflight_cnt) < CW'(OBUF_DEPTH));
    end

    // ------------------------------------------------------ latency pipeline
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = r_en;
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight_cnt = inflight_cnt + CW'(pipe_q[i]);
        end
    end

    assign capture = pipe_q[RD_LAT-1];
    assign m_valid = (obuf_cnt_q != '0);
    assign m_data  = obuf_q[rd_ptr_q];
    assign xfer    = m_valid && m_ready;
    assign busy    = (inflight_cnt != '0) || (obuf_cnt_q != '0);

    // --------------------------------------------------------- output buffer
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            pipe_q     <= '0;
            obuf_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            word_cnt   <= '0;
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                obuf_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
            if (capture) begin
                obuf_q[wr_ptr_q] <= rdata;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (xfer) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                word_cnt <= word_cnt + CNT_W'(1);
            end
            case ({capture, xfer})
                2'b10:   obuf_cnt_q <= obuf_cnt_q + CW'(1);
                2'b01:   obuf_cnt_q <= obuf_cnt_q - CW'(1);
                default: obuf_cnt_q <= obuf_cnt_q;
            endcase
        end
    end

`ifdef FIFO_RD_DRAIN_STALL_CNT_EN
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
